writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Merges the single-cycle ALU result path and the multi-cycle load/IO return path into one
//  registered write port that drives writeRegister/writeAddress/writeData of the register file.
//  The ALU has priority. Load/IO returns are queued in a small FIFO.
//  Writes to registers the register file rewrites every cycle (28 = PC, 29 = tucanos) are discarded.
//  Decode gets pending-write hits so it can stall on queued loads.
// PARAMETERS
//  DEPTH        4   load/IO FIFO entries; power of 2, >= 2
//  STARVE_LIMIT 8   cycles a non-empty FIFO may go unserved before alu_hold is raised; >= 1
//  RESERVED_A   28  discarded destination address (PC mirror)
//  RESERVED_B   29  discarded destination address (tucanos mirror)
// PORTS
//  clock          in   1   single clock, all state on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  alu_valid      in   1   ALU result valid this cycle; cannot be back-pressured
//  alu_address    in   5   ALU destination register
//  alu_data       in   32  ALU result
//  mem_valid      in   1   load/IO return valid
//  mem_ready      out  1   FIFO can accept; equals !full, combinational from FIFO count
//  mem_address    in   5   load/IO destination register
//  mem_data       in   32  load/IO data
//  alu_hold       out  1   registered; upstream must drive alu_valid=0 on the cycle after it is seen high
//  read_address1  in   5   decode source register 1
//  read_address2  in   5   decode source register 2
//  pending_hit1   out  1   combinational; a queued FIFO entry targets read_address1
//  pending_hit2   out  1   combinational; a queued FIFO entry targets read_address2
//  writeRegister  out  1   registered write enable to the register file
//  writeAddress   out  5   registered write address
//  writeData      out  32  registered write data
//  dropped_write  out  1   registered one-cycle pulse: an accepted write targeted RESERVED_A/B
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - FIFO is emptied and queued writes are lost. Starvation counter is zeroed.
//   - All registered outputs go to 0 immediately. mem_ready=1.
//   - Reset mid-operation: same as above; no partial write is issued.
//  FIFO push
//   - Occurs on mem_valid & mem_ready.
//   - Every load/IO write goes through the FIFO; there is no bypass, even when the FIFO is empty.
//  Selection, at each posedge
//   - If alu_valid: the ALU is selected.
//   - Else if the FIFO is non-empty: the head is popped and selected.
//   - Else: writeRegister <= 0. writeAddress/writeData hold their previous values.
//  Push and pop in the same cycle are allowed. The count is unchanged.
//   - Full stays full, but mem_ready=0 prevents any push while full.
//  Discard rule
//   - If the selected address is RESERVED_A or RESERVED_B: writeRegister <= 0 and dropped_write <= 1.
//   - A discarded FIFO entry is still popped.
//  Latency (register file commit edge)
//   - ALU: sampled at edge k, writeRegister high during cycle k..k+1, register file commits at edge k+1.
//   - Load into an empty, unblocked FIFO: pushed at edge k, popped at edge k+1, committed at edge k+2.
//  Ordering
//   - FIFO entries leave in push order.
//   - The ALU may overtake queued loads. Decode must stall on pending_hit to preserve RAW order.
//  Starvation
//   - The counter increments each cycle the FIFO is non-empty and no pop occurs.
//   - It clears on a pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
//   - alu_hold <= 1 when counter == STARVE_LIMIT. It stays high until the edge after the next pop.
//   - alu_valid high while alu_hold is high is a protocol violation. The ALU still wins; the bench flags it.
//  Width rules
//   - FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - The count is log2(DEPTH)+1 bits, so full (count==DEPTH) and empty (count==0) are distinct.
//  pending_hit*
//   - Compares only valid FIFO entries.
//   - The entry being popped this cycle still counts as pending.
// TESTING
//  1 Reset:
//    - reset_n=0 mid-stream with 3 entries queued -> outputs 0 at once, mem_ready=1.
//    - No writeRegister pulse after release.
//  2 ALU alone: alu_valid=1, addr 5, data 0xDEADBEEF at edge k -> writeRegister=1, writeAddress=5, writeData=0xDEADBEEF after edge k.
//  3 Load: mem_valid once, addr 7, data 0x12 with an empty FIFO and alu_valid=0 -> writeRegister=1 exactly one cycle later than an ALU write would be.
//  4 Full: push 4 loads while alu_valid=1 -> mem_ready=0 after the 4th push.
//    - A 5th mem_valid is not accepted.
//    - Drain order is 1,2,3,4.
//  5 Starvation: FIFO non-empty, alu_valid=1 for 8 cycles -> alu_hold=1.
//    - Next cycle alu_valid=0 -> head popped, alu_hold falls one cycle later.
//  6 Reserved/hazard:
//    - ALU write to addr 29 -> writeRegister=0, dropped_write pulses.
//    - Queued load to addr 3 with read_address1=3 -> pending_hit1=1 until its pop edge.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Writeback port bundle: ALU result, load/IO return, decode hazard query and register-file write.
// slave = the arbiter, master = the upstream pipeline and register file.
interface writeback_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_address;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_address;
   logic [31:0] mem_data;
   logic        alu_hold;
   logic [4:0]  read_address1;
   logic [4:0]  read_address2;
   logic        pending_hit1;
   logic        pending_hit2;
   logic        writeRegister;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic        dropped_write;

   modport slave (
      input  alu_valid, alu_address, alu_data,
      input  mem_valid, mem_address, mem_data,
      input  read_address1, read_address2,
      output mem_ready, alu_hold, pending_hit1, pending_hit2,
      output writeRegister, writeAddress, writeData, dropped_write
   );

   modport master (
      output alu_valid, alu_address, alu_data,
      output mem_valid, mem_address, mem_data,
      output read_address1, read_address2,
      input  mem_ready, alu_hold, pending_hit1, pending_hit2,
      input  writeRegister, writeAddress, writeData, dropped_write
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results (priority) and queued load/IO returns into one registered register-file write port.
// ALU commits one edge after sampling, loads two; loads back-pressure via mem_ready, ALU via alu_hold.

module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        push_vld,
   input  logic [WIDTH-1:0]            push_dat,
   output logic                        push_rdy,
   input  logic                        pop_vld,
   output logic [WIDTH-1:0]            pop_dat,
   output logic                        empty,
   output logic [DEPTH-1:0]            entry_vld,
   output logic [DEPTH-1:0][WIDTH-1:0] entry_dat
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             rd_ptr;
   logic [PW:0]               count;
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic                      do_push;
   logic                      do_pop;

   assign empty     = (count == '0);
   assign push_rdy  = (count != FULL_CNT);
   assign do_push   = push_vld & push_rdy;
   assign do_pop    = pop_vld & ~empty;
   assign pop_dat   = mem[rd_ptr];
   assign entry_dat = mem;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   // Storage needs no reset: slots are only observed through entry_vld.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_comb begin
      entry_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_vld[i] = ({1'b0, PW'(i) - rd_ptr} < count);
      end
   end
endmodule

module writeback_arbiter #(
   parameter int          DEPTH        = 4,
   parameter int          STARVE_LIMIT = 8,
   parameter logic [4:0]  RESERVED_A   = 5'd28,
   parameter logic [4:0]  RESERVED_B   = 5'd29
) (
   input  logic               clock,
   input  logic               reset_n,
   writeback_arbiter_if.slave bus
);
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_req_t;

   localparam int EW = $bits(wb_req_t);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   wb_req_t                  push_req;
   wb_req_t                  head_req;
   wb_req_t                  sel_req;
   logic                     fifo_empty;
   logic                     pop_fire;
   logic                     sel_vld;
   logic                     sel_drop;
   logic [DEPTH-1:0]         entry_vld;
   logic [DEPTH-1:0][EW-1:0] entry_dat;
   logic [SW-1:0]            starve_cnt;
   logic                     write_en_q;
   logic                     drop_q;
   logic                     hold_q;
   logic [4:0]               addr_q;
   logic [31:0]              data_q;
   logic                     hit1;
   logic                     hit2;

   assign push_req = {bus.mem_address, bus.mem_data};

   // Every load goes through the queue, so a load never shares a cycle with its own commit.
   wb_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push_vld  (bus.mem_valid),
      .push_dat  (push_req),
      .push_rdy  (bus.mem_ready),
      .pop_vld   (~bus.alu_valid),
      .pop_dat   (head_req),
      .empty     (fifo_empty),
      .entry_vld (entry_vld),
      .entry_dat (entry_dat)
   );

   assign pop_fire = ~bus.alu_valid & ~fifo_empty;

   always_comb begin
      sel_vld  = bus.alu_valid | ~fifo_empty;
      sel_req  = bus.alu_valid ? {bus.alu_address, bus.alu_data} : head_req;
      sel_drop = sel_vld && ((sel_req.addr == RESERVED_A) || (sel_req.addr == RESERVED_B));
   end

   // The head being popped this cycle is still reported, so decode never races its commit.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_vld[i] && (entry_dat[i][EW-1 -: 5] == bus.read_address1)) hit1 = 1'b1;
         if (entry_vld[i] && (entry_dat[i][EW-1 -: 5] == bus.read_address2)) hit2 = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_en_q <= 1'b0;
         drop_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         write_en_q <= sel_vld & ~sel_drop;
         drop_q     <= sel_drop;
         if (sel_vld) begin
            addr_q <= sel_req.addr;
            data_q <= sel_req.data;
         end
      end
   end

   // Hold is taken from the pre-edge count, so it drops one edge after the pop that clears it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
         hold_q     <= 1'b0;
      end else begin
         hold_q <= (starve_cnt == STARVE_MAX);
         if (fifo_empty || pop_fire)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign bus.writeRegister = write_en_q;
   assign bus.writeAddress  = addr_q;
   assign bus.writeData     = data_q;
   assign bus.dropped_write = drop_q;
   assign bus.alu_hold      = hold_q;
   assign bus.pending_hit1  = hit1;
   assign bus.pending_hit2  = hit2;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, hand-written reset/full/starvation sequences,
// then random traffic against a queue-based reference model.
module tb_writeback_arbiter;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   writeback_arbiter_if wb ();

   writeback_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (LIMIT),
      .RESERVED_A   (5'd28),
      .RESERVED_B   (5'd29)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (wb)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   int          m_starve;
   logic        e_wr, e_drop, e_hold;
   logic [4:0]  e_addr;
   logic [31:0] e_data;

   function automatic void model_reset();
      mq.delete();
      m_starve = 0;
      e_wr = 0; e_drop = 0; e_hold = 0; e_addr = '0; e_data = '0;
   endfunction

   function automatic logic model_ready();
      return mq.size() < DEPTH;
   endfunction

   function automatic logic model_hit(input logic [4:0] r);
      foreach (mq[i]) if (mq[i].a == r) return 1'b1;
      return 1'b0;
   endfunction

   // Advances the model across one posedge using the inputs currently applied.
   function automatic void model_edge();
      bit   push, pop, sel;
      ent_t s;
      push   = wb.mem_valid && (mq.size() < DEPTH);
      pop    = !wb.alu_valid && (mq.size() > 0);
      e_hold = (m_starve == LIMIT);
      if (mq.size() > 0 && !pop) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                       m_starve = 0;
      sel = 1'b1;
      if (wb.alu_valid) s = '{a: wb.alu_address, d: wb.alu_data};
      else if (pop)     s = mq.pop_front();
      else begin        s = '0; sel = 1'b0; end
      if (push) mq.push_back('{a: wb.mem_address, d: wb.mem_data});
      if (sel) begin
         e_addr = s.a;
         e_data = s.d;
         e_drop = (s.a == 5'd28) || (s.a == 5'd29);
         e_wr   = !e_drop;
      end else begin
         e_wr   = 1'b0;
         e_drop = 1'b0;
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2);
      wb.alu_valid = av;  wb.alu_address = aa; wb.alu_data = ad;
      wb.mem_valid = mv;  wb.mem_address = ma; wb.mem_data = md;
      wb.read_address1 = r1; wb.read_address2 = r2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [4:0] pick_addr();
      int unsigned v;
      v = $urandom_range(0, 9);
      if (v == 8) return 5'd28;
      if (v == 9) return 5'd29;
      return 5'(v);
   endfunction

   always @(posedge clock) begin
      if (reset_n && wb.alu_valid && wb.alu_hold) begin
         fails++;
         $display("FAIL protocol: alu_valid=1 while alu_hold=1 (t=%0t)", $time);
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        av;  logic [4:0] aa; logic [31:0] ad;
      logic        mv;  logic [4:0] ma; logic [31:0] md;
      logic [4:0]  r1;  logic [4:0] r2;
      logic        x_rdy, x_h1, x_h2;
      logic        x_wr, x_drop, x_chk_ad;
      logic [4:0]  x_a; logic [31:0] x_d;
   } vec_t;

   vec_t vt [9];

   initial begin
      vt[0] = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,  5'd0, 5'd0, 1, 0, 0, 1, 0, 1, 5'd5, 32'hDEADBEEF};
      vt[1] = '{0, 5'd0,  32'h0,        1, 5'd7, 32'h12, 5'd7, 5'd0, 1, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF};
      vt[2] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd7, 5'd0, 1, 1, 0, 1, 0, 1, 5'd7, 32'h12};
      vt[3] = '{1, 5'd29, 32'h1,        0, 5'd0, 32'h0,  5'd7, 5'd0, 1, 0, 0, 0, 1, 0, 5'd0, 32'h0};
      vt[4] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0};
      vt[5] = '{1, 5'd28, 32'h2,        1, 5'd3, 32'h33, 5'd3, 5'd0, 1, 0, 0, 0, 1, 0, 5'd0, 32'h0};
      vt[6] = '{1, 5'd1,  32'h11,       0, 5'd0, 32'h0,  5'd3, 5'd3, 1, 1, 1, 1, 0, 1, 5'd1, 32'h11};
      vt[7] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd3, 5'd0, 1, 1, 0, 1, 0, 1, 5'd3, 32'h33};
      vt[8] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd3, 5'd0, 1, 0, 0, 0, 0, 1, 5'd3, 32'h33};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic av;
      idle();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("reset_wr",    wb.writeRegister, 0);
      chk("reset_addr",  wb.writeAddress,  0);
      chk("reset_data",  wb.writeData,     0);
      chk("reset_drop",  wb.dropped_write, 0);
      chk("reset_hold",  wb.alu_hold,      0);
      chk("reset_ready", wb.mem_ready,     1);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 9; i++) begin
         drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].mv, vt[i].ma, vt[i].md, vt[i].r1, vt[i].r2);
         #1;
         chk($sformatf("vec%0d_ready", i), wb.mem_ready, vt[i].x_rdy);
         chk($sformatf("vec%0d_hit1", i), wb.pending_hit1, vt[i].x_h1);
         chk($sformatf("vec%0d_hit2", i), wb.pending_hit2, vt[i].x_h2);
         tick();
         chk($sformatf("vec%0d_wr", i), wb.writeRegister, vt[i].x_wr);
         chk($sformatf("vec%0d_drop", i), wb.dropped_write, vt[i].x_drop);
         chk($sformatf("vec%0d_hold", i), wb.alu_hold, 0);
         if (vt[i].x_chk_ad) begin
            chk($sformatf("vec%0d_addr", i), wb.writeAddress, vt[i].x_a);
            chk($sformatf("vec%0d_data", i), wb.writeData, vt[i].x_d);
         end
      end

      // Fill the FIFO behind continuous ALU traffic, then drain it.
      for (int k = 0; k < 4; k++) begin
         drive(1, 5'(10 + k), 32'hA0 + k, 1, 5'(k + 1), 32'h100 + k + 1, 0, 0);
         #1;
         chk($sformatf("full_ready_pre%0d", k), wb.mem_ready, 1);
         tick();
         chk($sformatf("full_alu_addr%0d", k), wb.writeAddress, 10 + k);
      end
      drive(1, 5'd20, 32'hB0, 1, 5'd5, 32'h105, 0, 0);
      #1;
      chk("full_ready_after4", wb.mem_ready, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         idle();
         tick();
         chk($sformatf("drain%0d_wr", k), wb.writeRegister, 1);
         chk($sformatf("drain%0d_addr", k), wb.writeAddress, k + 1);
         chk($sformatf("drain%0d_data", k), wb.writeData, 32'h100 + k + 1);
      end
      tick();
      chk("drain_no_fifth", wb.writeRegister, 0);

      // Starvation: one queued load, ALU busy every cycle.
      drive(1, 5'd11, 32'h1, 1, 5'd9, 32'h99, 0, 0);
      tick();
      drive(1, 5'd12, 32'h2, 0, 0, 0, 0, 0);
      for (int j = 1; j <= 9; j++) begin
         tick();
         chk($sformatf("starve_hold_e%0d", j), wb.alu_hold, (j == 9));
      end
      idle();
      tick();
      chk("starve_pop_wr",   wb.writeRegister, 1);
      chk("starve_pop_addr", wb.writeAddress,  9);
      chk("starve_pop_data", wb.writeData,     32'h99);
      chk("starve_hold_pop", wb.alu_hold,      1);
      tick();
      chk("starve_hold_fall", wb.alu_hold, 0);

      // Reset mid-stream with three queued loads and a live write on the port.
      for (int k = 0; k < 3; k++) begin
         drive(1, 5'd13, 32'h55, 1, 5'd2, 32'h200 + k, 0, 0);
         tick();
      end
      chk("prereset_wr", wb.writeRegister, 1);
      idle();
      wb.read_address1 = 5'd2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("midreset_wr",    wb.writeRegister, 0);
      chk("midreset_addr",  wb.writeAddress,  0);
      chk("midreset_data",  wb.writeData,     0);
      chk("midreset_ready", wb.mem_ready,     1);
      chk("midreset_hit1",  wb.pending_hit1,  0);
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("postreset_wr%0d", k), wb.writeRegister, 0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         av = ($urandom_range(0, 99) < 45) && !e_hold;
         drive(av, pick_addr(), $urandom(), ($urandom_range(0, 99) < 55), pick_addr(), $urandom(),
               pick_addr(), pick_addr());
         #1;
         chk("rnd_ready", wb.mem_ready,    model_ready());
         chk("rnd_hit1",  wb.pending_hit1, model_hit(wb.read_address1));
         chk("rnd_hit2",  wb.pending_hit2, model_hit(wb.read_address2));
         tick();
         chk("rnd_wr",   wb.writeRegister, e_wr);
         chk("rnd_drop", wb.dropped_write, e_drop);
         chk("rnd_hold", wb.alu_hold,      e_hold);
         if (e_wr) begin
            chk("rnd_addr", wb.writeAddress, e_addr);
            chk("rnd_data", wb.writeData,    e_data);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
